local_bias_ctrl: RTL

Digital sequencer and test-bus arbiter for the local_bias analog block. It drives the bias power-down (pdb) with a timed settle/discharge sequence and raises bias_rdy only after the mirrored currents and vcas have settled. It watches a digital supply-good flag for the 1.8 V / 0.8 V rails and shares the 2-bit analog test bus enable (atb_ena) between two requesters: debug host and BIST.

---
 rtl/local_bias_if.sv | 22 ++
 rtl/local_bias_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/local_bias_if.sv
// local_bias_if: control, supply and test-bus arbitration signals between local_bias_ctrl and its host.
interface local_bias_if;
  logic       en;
  logic       supply_ok;
  logic       fault_clr;
  logic [1:0] atb_req;
  logic [1:0] atb_sel0;
  logic [1:0] atb_sel1;
  logic       pdb;
  logic       bias_rdy;
  logic       fault;
  logic [1:0] atb_gnt;
  logic [1:0] atb_ena;
  modport master (
    output en, supply_ok, fault_clr, atb_req, atb_sel0, atb_sel1,
    input  pdb, bias_rdy, fault, atb_gnt, atb_ena
  );
  modport slave (
    input  en, supply_ok, fault_clr, atb_req, atb_sel0, atb_sel1,
    output pdb, bias_rdy, fault, atb_gnt, atb_ena
  );
endinterface

// File: rtl/local_bias_ctrl.sv
// local_bias_ctrl: bias power sequencer with supply fault latch and two-requester round-robin test-bus arbiter.
module local_bias_ctrl #(
  parameter int SETTLE_CYC = 64,
  parameter int DISCH_CYC  = 16,
  parameter int CNT_W      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  local_bias_if.slave  bus
);
  typedef enum logic [1:0] {OFF, RAMP, ON, DRAIN} state_t;
  typedef enum logic [1:0] {A_IDLE, A_GRANT, A_GAP} arb_t;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DISCH_LAST  = CNT_W'(DISCH_CYC - 1);
  state_t           r_state, w_state_nxt;
  arb_t             r_arb, w_arb_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_fault, w_fault_nxt, w_set;
  logic             r_pdb, r_rdy;
  logic             r_ptr, w_ptr_nxt, w_pick, w_act;
  logic [1:0]       r_gnt, w_gnt_nxt, r_ena, w_ena_nxt;
  always_comb begin
    w_state_nxt = r_state;
    w_set       = 1'b0;
    case (r_state)
      OFF:   if (bus.en && bus.supply_ok && !r_fault) w_state_nxt = RAMP;
      RAMP: begin
        if (!bus.supply_ok) begin
          w_state_nxt = DRAIN;
          w_set       = 1'b1;
        end else if (!bus.en) w_state_nxt = DRAIN;
        else if (r_cnt == SETTLE_LAST) w_state_nxt = ON;
      end
      ON: begin
        if (!bus.supply_ok) begin
          w_state_nxt = DRAIN;
          w_set       = 1'b1;
        end else if (!bus.en) w_state_nxt = DRAIN;
      end
      DRAIN: if (r_cnt == DISCH_LAST) w_state_nxt = OFF;
      default: w_state_nxt = OFF;
    endcase
    w_cnt_nxt   = (w_state_nxt != r_state || r_state == OFF || r_state == ON) ? '0 : r_cnt + 1'b1;
    w_fault_nxt = w_set | (r_fault & ~bus.fault_clr);
  end
  // The arbiter only runs while the bias stays ON; any exit drops the grant on the same edge as pdb.
  always_comb begin
    w_act     = (r_state == ON) && (w_state_nxt == ON);
    w_pick    = (bus.atb_req == 2'b11) ? r_ptr : bus.atb_req[1];
    w_arb_nxt = r_arb;
    w_ptr_nxt = r_ptr;
    w_gnt_nxt = r_gnt;
    w_ena_nxt = r_ena;
    if (!w_act) begin
      w_arb_nxt = A_IDLE;
      w_gnt_nxt = 2'b00;
      w_ena_nxt = 2'b00;
    end else begin
      case (r_arb)
        A_IDLE: if (|bus.atb_req) begin
          w_gnt_nxt = w_pick ? 2'b10 : 2'b01;
          w_ena_nxt = w_pick ? bus.atb_sel1 : bus.atb_sel0;
          w_ptr_nxt = ~w_pick;
          w_arb_nxt = A_GRANT;
        end
        A_GRANT: if (!(|(bus.atb_req & r_gnt))) begin
          w_gnt_nxt = 2'b00;
          w_ena_nxt = 2'b00;
          w_arb_nxt = A_GAP;
        end
        default: w_arb_nxt = A_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OFF;
      r_cnt   <= '0;
      r_fault <= 1'b0;
      r_pdb   <= 1'b0;
      r_rdy   <= 1'b0;
      r_arb   <= A_IDLE;
      r_ptr   <= 1'b0;
      r_gnt   <= 2'b00;
      r_ena   <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fault <= w_fault_nxt;
      r_pdb   <= (w_state_nxt == RAMP) || (w_state_nxt == ON);
      r_rdy   <= (w_state_nxt == ON);
      r_arb   <= w_arb_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ena   <= w_ena_nxt;
    end
  end
  assign bus.pdb      = r_pdb;
  assign bus.bias_rdy = r_rdy;
  assign bus.fault    = r_fault;
  assign bus.atb_gnt  = r_gnt;
  assign bus.atb_ena  = r_ena;
endmodule
